hc_mmio_csr: RTL
================

HC_MMIO_CSR -- requirements
Module: hc_mmio_csr

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 2, number of buffer descriptors (legal 1..8).
REQ-002 SHALL have parameter BUFFER_BASE, default 16'h120, byte address of descriptor 0.
REQ-003 SHALL have parameter DSM_ADDR, default 16'h110, byte address of the DSM base register.
REQ-004 SHALL have parameter CONTROL_ADDR, default 16'h118, byte address of the control register.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port rx_c0  input  t_if_ccip_c0_Rx  CCI-P MMIO request channel (hdr, mmioRdValid, mmioWrValid, data).
REQ-008 SHALL have port tx_c2  output  t_if_ccip_c2_Tx  MMIO read response (mmioRdValid, hdr.tid, data).
REQ-009 SHALL have port done  input  1  datapath completion strobe.
REQ-010 SHALL have port dsm_base  output  64  DSM base address.
REQ-011 SHALL have port buffers  output  NUM_BUFFERS x t_hc_buffer  descriptor array (64b address, 32b size).
REQ-012 SHALL have port afu_reset_n  output  1  datapath reset, low while in S_RESET.
REQ-013 SHALL have ports start_pulse, stop_pulse  output  1 each  single-cycle strobes.
REQ-014 SHALL have port running  output  1  high while in S_RUN.

Function
REQ-015 SHALL decode MMIO addresses as DWORD index (byte address >> 2) from t_ccip_c0_ReqMmioHdr; map: DSM at DSM_ADDR (64b), control at CONTROL_ADDR (32b), descriptor i address at BUFFER_BASE+16*i (64b), size at BUFFER_BASE+16*i+8 (32b, low 32 bits of write data).
REQ-016 SHALL update a register on the cycle after mmioWrValid with a matching address; writes to unmapped addresses are dropped.
REQ-017 SHALL ignore descriptor and DSM writes while in S_RUN (configuration lock).
REQ-018 SHALL answer every mmioRdValid exactly one cycle later with tx_c2.mmioRdValid=1, tid echoed, data = register value zero-extended to 64b; unmapped reads return 0.
REQ-019 SHALL return {29'b0, state} for control-register reads.
REQ-020 SHALL implement FSM S_RESET, S_IDLE, S_RUN, S_DONE, S_STOP driven by control writes: 0x0 -> S_RESET from any state; 0x1 -> S_IDLE from S_RESET/S_DONE/S_STOP; 0x3 -> S_RUN from S_IDLE only, asserting start_pulse one cycle; 0x7 -> S_STOP from S_RUN only, asserting stop_pulse one cycle; other values/transitions ignored.
REQ-021 SHALL move S_RUN -> S_DONE on done=1; a STOP write in the same cycle as done takes priority (S_STOP, stop_pulse).
REQ-022 SHALL ignore done outside S_RUN.
REQ-023 SHALL register all outputs; no combinational path from rx_c0 to any output.

Reset
REQ-024 SHALL, on reset_n=0 at a clock edge, set state S_RESET, dsm_base=0, all descriptors=0, pulses=0, running=0, afu_reset_n=0, tx_c2.mmioRdValid=0.
REQ-025 SHALL drop any read response pending when reset is applied.

Structure
REQ-026 SHALL place t_hc_buffer, t_hc_address, t_hc_control, state enum and HC_CONTROL_* codes in shared package hc_csr_pkg.
REQ-027 SHALL isolate address decode in one sub-module hc_mmio_decode (combinational, outputs select one-hot and descriptor index).

Verification
REQ-028 SHALL cover: write 0x1000 to 0x110, read 0x110 tid=5 -> one cycle later tx_c2 valid, tid=5, data=0x1000.
REQ-029 SHALL cover: NUM_BUFFERS=4, write buffer 3 address 0xABCD000 at 0x150, size 64 at 0x158 -> buffers[3]={0xABCD000,64}, others 0.
REQ-030 SHALL cover: control writes 1 then 3 -> start_pulse high exactly one cycle, running=1, afu_reset_n=1; write to 0x120 then ignored.
REQ-031 SHALL cover: in S_RUN, done and STOP write same cycle -> S_STOP, stop_pulse one cycle, control read returns 4.
REQ-032 SHALL cover: read of unmapped 0x300 -> response data 0; write 3 from S_RESET -> no start_pulse, state unchanged.
REQ-033 SHALL cover: reset_n low during S_RUN with read pending -> no response, all outputs at reset values next cycle.

Source files
------------

// File: rtl/hc_csr_pkg.sv
// Shared types for the host-controlled MMIO CSR block: CCI-P MMIO channel
// structs, buffer descriptors, control FSM states and control command codes.
package hc_csr_pkg;

  typedef logic [15:0] t_ccip_mmioAddr;
  typedef logic [8:0]  t_ccip_tid;
  typedef logic [63:0] t_ccip_mmioData;

  // MMIO request header; address is a DWORD index, not a byte address
  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic                mmioRdValid;
    logic                mmioWrValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef logic [63:0] t_hc_address;
  typedef logic [31:0] t_hc_control;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_STOP  = 3'd4
  } t_hc_state;

  localparam t_hc_control HC_CONTROL_ASSERT_RST   = 32'h0;
  localparam t_hc_control HC_CONTROL_DEASSERT_RST = 32'h1;
  localparam t_hc_control HC_CONTROL_START        = 32'h3;
  localparam t_hc_control HC_CONTROL_STOP         = 32'h7;

  // Bit positions of the one-hot register select produced by the decoder
  localparam int SEL_DSM      = 0;
  localparam int SEL_CTRL     = 1;
  localparam int SEL_BUF_ADDR = 2;
  localparam int SEL_BUF_SIZE = 3;
  localparam int SEL_W        = 4;

  function automatic t_ccip_mmioData hc_status_word(input t_hc_state s);
    return 64'({29'b0, s});
  endfunction

endpackage

// File: rtl/hc_mmio_csr_if.sv
// Host-side bundle of the CCI-P MMIO request and response channels.
interface hc_mmio_csr_if
  import hc_csr_pkg::*;
();

  t_if_ccip_c0_Rx rx_c0;
  t_if_ccip_c2_Tx tx_c2;

  modport master (output rx_c0, input tx_c2);
  modport slave  (input rx_c0, output tx_c2);

endinterface

// File: rtl/hc_mmio_decode.sv
// Combinational MMIO address decoder: DWORD index to one-hot register select
// plus descriptor index.
module hc_mmio_decode
  import hc_csr_pkg::*;
#(
  parameter int          NUM_BUFFERS  = 2,
  parameter logic [15:0] BUFFER_BASE  = 16'h120,
  parameter logic [15:0] DSM_ADDR     = 16'h110,
  parameter logic [15:0] CONTROL_ADDR = 16'h118
) (
  input  t_ccip_mmioAddr   addr,
  output logic [SEL_W-1:0] sel,
  output logic [2:0]       buf_idx
);

  localparam t_ccip_mmioAddr DSM_DW   = DSM_ADDR >> 2;
  localparam t_ccip_mmioAddr CTRL_DW  = CONTROL_ADDR >> 2;
  localparam t_ccip_mmioAddr BUF_DW   = BUFFER_BASE >> 2;
  localparam t_ccip_mmioAddr BUF_SPAN = t_ccip_mmioAddr'(4 * NUM_BUFFERS);

  t_ccip_mmioAddr buf_off;

  assign buf_off = addr - BUF_DW;

  // Each descriptor spans four DWORDs: address at +0, size at +2
  always_comb begin
    sel     = '0;
    buf_idx = '0;
    if (addr == DSM_DW) begin
      sel[SEL_DSM] = 1'b1;
    end else if (addr == CTRL_DW) begin
      sel[SEL_CTRL] = 1'b1;
    end else if ((addr >= BUF_DW) && (buf_off < BUF_SPAN)) begin
      buf_idx = buf_off[4:2];
      if (buf_off[1:0] == 2'd0) begin
        sel[SEL_BUF_ADDR] = 1'b1;
      end else if (buf_off[1:0] == 2'd2) begin
        sel[SEL_BUF_SIZE] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc_mmio_csr.sv
// MMIO control/status register block: DSM base, buffer descriptors and the
// run-control FSM, with single-cycle registered read responses.
module hc_mmio_csr
  import hc_csr_pkg::*;
#(
  parameter int          NUM_BUFFERS  = 2,
  parameter logic [15:0] BUFFER_BASE  = 16'h120,
  parameter logic [15:0] DSM_ADDR     = 16'h110,
  parameter logic [15:0] CONTROL_ADDR = 16'h118
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  t_if_ccip_c0_Rx               rx_c0,
  output t_if_ccip_c2_Tx               tx_c2,
  input  logic                         done,
  output t_hc_address                  dsm_base,
  output t_hc_buffer [NUM_BUFFERS-1:0] buffers,
  output logic                         afu_reset_n,
  output logic                         start_pulse,
  output logic                         stop_pulse,
  output logic                         running
);

  t_ccip_c0_ReqMmioHdr          mmio_hdr;
  logic [SEL_W-1:0]             sel;
  logic [2:0]                   buf_idx;
  logic                         ctrl_wr;
  logic                         cfg_wr;

  t_hc_state                    state_q, state_d;
  t_hc_address                  dsm_q, dsm_d;
  t_hc_buffer [NUM_BUFFERS-1:0] buffers_q, buffers_d;
  t_if_ccip_c2_Tx               tx_c2_q, tx_c2_d;
  logic                         start_pulse_q, start_pulse_d;
  logic                         stop_pulse_q, stop_pulse_d;
  logic                         running_q, running_d;
  logic                         afu_reset_n_q, afu_reset_n_d;

  logic                         unused_hdr_bits;

  assign mmio_hdr        = rx_c0.hdr;
  assign unused_hdr_bits = ^{mmio_hdr.length, mmio_hdr.rsvd};

  hc_mmio_decode #(
    .NUM_BUFFERS  (NUM_BUFFERS),
    .BUFFER_BASE  (BUFFER_BASE),
    .DSM_ADDR     (DSM_ADDR),
    .CONTROL_ADDR (CONTROL_ADDR)
  ) u_decode (
    .addr    (mmio_hdr.address),
    .sel     (sel),
    .buf_idx (buf_idx)
  );

  assign ctrl_wr = rx_c0.mmioWrValid && sel[SEL_CTRL];
  // Configuration is frozen while the datapath is consuming it
  assign cfg_wr  = rx_c0.mmioWrValid && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // A control write that changes state wins over a same-cycle done
  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      case (rx_c0.data[31:0])
        HC_CONTROL_ASSERT_RST: state_d = S_RESET;
        HC_CONTROL_DEASSERT_RST: begin
          if (state_q inside {S_RESET, S_DONE, S_STOP}) state_d = S_IDLE;
        end
        HC_CONTROL_START: begin
          if (state_q == S_IDLE) state_d = S_RUN;
        end
        HC_CONTROL_STOP: begin
          if (state_q == S_RUN) state_d = S_STOP;
        end
        default: ;
      endcase
    end
    if ((state_q == S_RUN) && (state_d == S_RUN) && done) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    start_pulse_d = (state_q == S_IDLE) && (state_d == S_RUN);
    stop_pulse_d  = (state_q == S_RUN) && (state_d == S_STOP);
    running_d     = (state_d == S_RUN);
    afu_reset_n_d = (state_d != S_RESET);
  end

  always_comb begin
    dsm_d     = dsm_q;
    buffers_d = buffers_q;
    if (cfg_wr) begin
      if (sel[SEL_DSM]) dsm_d = rx_c0.data;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (buf_idx == i[2:0]) begin
          if (sel[SEL_BUF_ADDR]) buffers_d[i].address = rx_c0.data;
          if (sel[SEL_BUF_SIZE]) buffers_d[i].size    = rx_c0.data[31:0];
        end
      end
    end
  end

  // Read data reflects register contents before any same-cycle write
  always_comb begin
    tx_c2_d             = '0;
    tx_c2_d.mmioRdValid = rx_c0.mmioRdValid;
    tx_c2_d.hdr.tid     = mmio_hdr.tid;
    if (sel[SEL_DSM])  tx_c2_d.data = dsm_q;
    if (sel[SEL_CTRL]) tx_c2_d.data = hc_status_word(state_q);
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (buf_idx == i[2:0]) begin
        if (sel[SEL_BUF_ADDR]) tx_c2_d.data = buffers_q[i].address;
        if (sel[SEL_BUF_SIZE]) tx_c2_d.data = 64'(buffers_q[i].size);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dsm_q         <= '0;
      buffers_q     <= '0;
      tx_c2_q       <= '0;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
      running_q     <= 1'b0;
      afu_reset_n_q <= 1'b0;
    end else begin
      dsm_q         <= dsm_d;
      buffers_q     <= buffers_d;
      tx_c2_q       <= tx_c2_d;
      start_pulse_q <= start_pulse_d;
      stop_pulse_q  <= stop_pulse_d;
      running_q     <= running_d;
      afu_reset_n_q <= afu_reset_n_d;
    end
  end

  assign tx_c2       = tx_c2_q;
  assign dsm_base    = dsm_q;
  assign buffers     = buffers_q;
  assign start_pulse = start_pulse_q;
  assign stop_pulse  = stop_pulse_q;
  assign running     = running_q;
  assign afu_reset_n = afu_reset_n_q;

endmodule
